// File: rtl/edge_cnt_pkg.sv
// Shared definitions for the edge counter and its register wrappers.
//   edge_mode_e : edge-select encoding carried on mode_i
//   edge_hit()  : maps a mode plus rise/fall strobes to a single hit bit
package edge_cnt_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    RISE = 2'd1,
    FALL = 2'd2,
    BOTH = 2'd3
  } edge_mode_e;

  localparam int unsigned EDGE_MIN_STAGE = 2;

  function automatic logic edge_hit(edge_mode_e mode, logic re, logic fe);
    logic hit;
    case (mode)
      RISE:    hit = re;
      FALL:    hit = fe;
      BOTH:    hit = re | fe;
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/edge_det.sv
// Synchronizer plus edge detector for one asynchronous level.
//   clk_i   : clock (rising edge)
//   rst_n_i : asynchronous active-low reset, clears every flop
//   dat_i   : asynchronous input level
//   dat_o   : synchronized level (last synchronizer flop)
//   re_o    : registered one-cycle rising-edge strobe
//   fe_o    : registered one-cycle falling-edge strobe
// Latency: a level sampled at edge n shows on re_o/fe_o after edge n+STAGE.
module edge_det #(
  parameter int STAGE = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic dat_i,
  output logic dat_o,
  output logic re_o,
  output logic fe_o
);

  logic [STAGE-1:0] sync_q;
  logic             dly_q;
  logic             re_q;
  logic             fe_q;
  logic             synced;

  assign synced = sync_q[STAGE-1];

  // Shift chain; bit 0 is the metastability-catching flop.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
      re_q   <= 1'b0;
      fe_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGE-2:0], dat_i};
      dly_q  <= synced;
      re_q   <= synced & ~dly_q;
      fe_q   <= ~synced & dly_q;
    end
  end

  assign dat_o = synced;
  assign re_o  = re_q;
  assign fe_o  = fe_q;

endmodule

// File: rtl/edge_cnt.sv
// Edge counter: counts selected edges of an asynchronous level.
//   clk_i   : clock (rising edge)
//   rst_n_i : asynchronous active-low reset
//   dat_i   : asynchronous level to monitor
//   en_i    : counting enable (detection keeps running while low)
//   clr_i   : synchronous clear of count, overflow and pulses; beats a hit
//   mode_i  : edge select (NONE/RISE/FALL/BOTH)
//   cmp_i   : compare value for match_o
//   cnt_o   : registered edge count, wraps modulo 2^CNT_WIDTH
//   edge_o  : one-cycle pulse in the cycle an increment becomes visible
//   match_o : one-cycle pulse when an increment lands on cmp_i
//   ovf_o   : sticky wrap flag
module edge_cnt
  import edge_cnt_pkg::*;
#(
  parameter int STAGE     = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 dat_i,
  input  logic                 en_i,
  input  logic                 clr_i,
  input  logic [1:0]           mode_i,
  input  logic [CNT_WIDTH-1:0] cmp_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 edge_o,
  output logic                 match_o,
  output logic                 ovf_o
);

  logic                 re;
  logic                 fe;
  logic                 sync_lvl;
  logic                 unused_lvl;
  logic                 hit;
  logic [CNT_WIDTH-1:0] cnt_inc;

  logic [CNT_WIDTH-1:0] cnt_q,   cnt_d;
  logic                 edge_q,  edge_d;
  logic                 match_q, match_d;
  logic                 ovf_q,   ovf_d;

  edge_det #(
    .STAGE(STAGE)
  ) u_edge_det (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .dat_i  (dat_i),
    .dat_o  (sync_lvl),
    .re_o   (re),
    .fe_o   (fe)
  );

  // The synchronized level itself is not needed here.
  assign unused_lvl = sync_lvl;

  // Enable and mode qualify the strobe at the counting edge only, so strobes
  // that fire while disabled are simply dropped.
  assign hit     = en_i & edge_hit(edge_mode_e'(mode_i), re, fe);
  assign cnt_inc = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  always_comb begin
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    edge_d  = 1'b0;
    match_d = 1'b0;
    if (clr_i) begin
      // Clear wins; a coincident hit is lost.
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (hit) begin
      cnt_d   = cnt_inc;
      edge_d  = 1'b1;
      match_d = (cnt_inc == cmp_i);
      if (&cnt_q) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q   <= '0;
      edge_q  <= 1'b0;
      match_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      edge_q  <= edge_d;
      match_q <= match_d;
      ovf_q   <= ovf_d;
    end
  end

  assign cnt_o   = cnt_q;
  assign edge_o  = edge_q;
  assign match_o = match_q;
  assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_edge_cnt.sv
// Directed bench for edge_cnt (STAGE=2, CNT_WIDTH=4).
module tb_edge_cnt;

  localparam int STAGE = 2;
  localparam int CW    = 4;

  logic          clk_i;
  logic          rst_n_i;
  logic          dat_i;
  logic          en_i;
  logic          clr_i;
  logic [1:0]    mode_i;
  logic [CW-1:0] cmp_i;
  logic [CW-1:0] cnt_o;
  logic          edge_o;
  logic          match_o;
  logic          ovf_o;

  int checks_cnt;
  int fail_cnt;
  int edges_seen;
  int match_seen;
  int match_wo_edge;

  edge_cnt #(
    .STAGE    (STAGE),
    .CNT_WIDTH(CW)
  ) dut (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .dat_i  (dat_i),
    .en_i   (en_i),
    .clr_i  (clr_i),
    .mode_i (mode_i),
    .cmp_i  (cmp_i),
    .cnt_o  (cnt_o),
    .edge_o (edge_o),
    .match_o(match_o),
    .ovf_o  (ovf_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input int got, input int exp);
    checks_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s got=%0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Advance n cycles, tallying output pulses.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      edges_seen += int'(edge_o);
      match_seen += int'(match_o);
      if (match_o && !edge_o) match_wo_edge++;
    end
  endtask

  task automatic pulse(input int hi, input int lo);
    dat_i = 1'b1;
    run(hi);
    dat_i = 1'b0;
    run(lo);
  endtask

  task automatic clear();
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    edges_seen = 0;
    match_seen = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks_cnt = 0; fail_cnt = 0;
    edges_seen = 0; match_seen = 0; match_wo_edge = 0;
    rst_n_i = 1'b0; dat_i = 1'b0; en_i = 1'b0; clr_i = 1'b0;
    mode_i = 2'd0; cmp_i = 4'd15;
    #1;
    check("rst_cnt",   int'(cnt_o),   0);
    check("rst_edge",  int'(edge_o),  0);
    check("rst_match", int'(match_o), 0);
    check("rst_ovf",   int'(ovf_o),   0);
    tick(); tick();
    rst_n_i = 1'b1;
    tick();

    // Basic rise path: count lands 3 edges after the sampling edge.
    en_i = 1'b1; mode_i = 2'd1;
    clear();
    dat_i = 1'b1;
    tick(); tick(); tick();
    check("rise_pre_cnt",  int'(cnt_o),  0);
    check("rise_pre_edge", int'(edge_o), 0);
    tick();
    check("rise_cnt",  int'(cnt_o),  1);
    check("rise_edge", int'(edge_o), 1);
    tick();
    check("rise_edge_off", int'(edge_o), 0);
    dat_i = 1'b0;
    edges_seen = 0;
    run(8);
    check("rise_fall_ign_cnt",   int'(cnt_o), 1);
    check("rise_fall_ign_edges", edges_seen,  0);

    // Fall-only mode.
    mode_i = 2'd2;
    clear();
    dat_i = 1'b1;
    run(6);
    check("fall_rise_ign", int'(cnt_o), 0);
    dat_i = 1'b0;
    run(6);
    check("fall_cnt", int'(cnt_o), 1);

    // Mode NONE counts nothing.
    mode_i = 2'd0;
    clear();
    pulse(4, 6);
    check("none_cnt", int'(cnt_o), 0);

    // Both edges: 4 pulses -> 8.
    mode_i = 2'd3;
    clear();
    for (int p = 0; p < 4; p++) pulse(4, 4);
    run(6);
    check("both_cnt",   int'(cnt_o), 8);
    check("both_edges", edges_seen,  8);
    check("both_match", match_seen,  0);

    // Wrap and compare with cmp=0.
    mode_i = 2'd1; cmp_i = 4'd0;
    clear();
    match_wo_edge = 0;
    for (int p = 0; p < 15; p++) pulse(2, 2);
    run(5);
    check("wrap15_cnt",   int'(cnt_o), 15);
    check("wrap15_ovf",   int'(ovf_o), 0);
    check("wrap15_match", match_seen,  0);
    pulse(2, 2);
    run(5);
    check("wrap_cnt",   int'(cnt_o), 0);
    check("wrap_ovf",   int'(ovf_o), 1);
    check("wrap_match", match_seen,  1);
    for (int p = 0; p < 3; p++) pulse(2, 2);
    run(5);
    check("wrap_more_cnt", int'(cnt_o), 3);
    check("ovf_sticky",    int'(ovf_o), 1);
    check("match_w_edge",  match_wo_edge, 0);
    match_seen = 0;
    cmp_i = 4'd3;
    run(3);
    check("cmp_change_nomatch", match_seen, 0);
    clear();
    check("clr_ovf", int'(ovf_o), 0);
    check("clr_cnt", int'(cnt_o), 0);

    // Clear priority over a coincident hit.
    cmp_i = 4'd15;
    for (int p = 0; p < 5; p++) pulse(2, 2);
    run(5);
    check("prio_pre_cnt", int'(cnt_o), 5);
    dat_i = 1'b1;
    tick(); tick(); tick();
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    check("prio_cnt",  int'(cnt_o),  0);
    check("prio_ovf",  int'(ovf_o),  0);
    check("prio_edge", int'(edge_o), 0);
    edges_seen = 0;
    run(6);
    dat_i = 1'b0;
    run(6);
    check("prio_lost_cnt",   int'(cnt_o), 0);
    check("prio_lost_edges", edges_seen,  0);

    // Disable window.
    pulse(2, 2); pulse(2, 2);
    run(5);
    check("dis_pre_cnt", int'(cnt_o), 2);
    en_i = 1'b0;
    for (int p = 0; p < 3; p++) pulse(2, 4);
    en_i = 1'b1;
    edges_seen = 0;
    run(8);
    check("dis_cnt",   int'(cnt_o), 2);
    check("dis_burst", edges_seen,  0);
    pulse(2, 2);
    run(5);
    check("dis_next_cnt",   int'(cnt_o), 3);
    check("dis_next_edges", edges_seen,  1);

    // Reset mid-count with dat_i high.
    clear();
    for (int p = 0; p < 7; p++) pulse(2, 2);
    run(5);
    check("rstm_pre_cnt", int'(cnt_o), 7);
    dat_i = 1'b1;
    rst_n_i = 1'b0;
    #1;
    check("rstm_cnt",   int'(cnt_o),   0);
    check("rstm_edge",  int'(edge_o),  0);
    check("rstm_match", int'(match_o), 0);
    check("rstm_ovf",   int'(ovf_o),   0);
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    tick(); tick(); tick();
    check("rstm_post_pre", int'(cnt_o), 0);
    tick();
    check("rstm_post_cnt",  int'(cnt_o),  1);
    check("rstm_post_edge", int'(edge_o), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
